// File: rtl/vga_pixel_tracker.sv
// vga_pixel_tracker: locks to a VGA raster from the PMOD bus and reports the first lit pixel each frame
module vga_pixel_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vga_in,
  output logic       locked,
  output logic       sync_err,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [5:0] pix_rgb,
  output logic       pix_multi,
  output logic       frame_tick
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] H_LO = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_TOT = 10'(V_TOTAL);
  localparam logic [9:0] V_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_HI = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [1:0] UNLOCK = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  logic [7:0] cur, prv;
  logic [10:0] hcnt_q, hcnt;
  logic [9:0] vcnt_q, vcnt, sx, sy;
  logic [5:0] srgb;
  logic [1:0] state, nxt;
  logic first_hs, line_bad, hit, smulti;
  logic hs_lead, vs_lead, active, lit, bad_line, clean, fail, report;
  // Edge detection, raster position, timing checks and next lock state
  always_comb begin
    hs_lead = prv[7] & ~cur[7];
    vs_lead = prv[3] & ~cur[3];
    hcnt = hs_lead ? 11'd0 : hcnt_q;
    vcnt = vs_lead ? 10'd0 : vcnt_q + {9'd0, hs_lead};
    active = hcnt >= H_LO && hcnt < H_HI && vcnt >= V_LO && vcnt < V_HI;
    lit = |{cur[6:4], cur[2:0]};
    bad_line = hs_lead & ~first_hs & (hcnt_q != H_TOT);
    clean = ~line_bad & ~bad_line & (vcnt_q == V_TOT);
    fail = (state == LOCKED) & (bad_line | (vs_lead & ~clean));
    report = vs_lead & (state == LOCKED) & clean & hit;
    nxt = state == UNLOCK ? (vs_lead ? CHECK : UNLOCK) :
          state == CHECK ? (vs_lead && clean ? LOCKED : CHECK) :
          state == LOCKED && !fail ? LOCKED : UNLOCK;
  end
  assign locked = state == LOCKED;
  // Input pipeline and line/frame counters; hcnt saturates so a lost hsync cannot wrap into a valid length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
      prv <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      cur <= vga_in;
      prv <= cur;
      hcnt_q <= &hcnt ? hcnt : hcnt + 11'd1;
      vcnt_q <= vcnt;
    end
  end
  // Line-length bookkeeping and first-lit-pixel capture into shadows, cleared at each frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_hs <= 1'b1;
      line_bad <= 1'b0;
      hit <= 1'b0;
      smulti <= 1'b0;
      sx <= '0;
      sy <= '0;
      srgb <= '0;
    end else begin
      first_hs <= fail ? 1'b1 : hs_lead ? 1'b0 : first_hs;
      line_bad <= vs_lead ? 1'b0 : bad_line ? 1'b1 : line_bad;
      if (vs_lead) begin
        hit <= 1'b0;
        smulti <= 1'b0;
      end else if (active && lit) begin
        if (!hit) begin
          hit <= 1'b1;
          sx <= 10'(hcnt - H_LO);
          sy <= vcnt - V_LO;
          srgb <= {cur[0], cur[4], cur[1], cur[5], cur[2], cur[6]};
        end else smulti <= 1'b1;
      end
    end
  end
  // Lock state, error/tick pulses and the held per-frame report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNLOCK;
      sync_err <= 1'b0;
      pix_valid <= 1'b0;
      frame_tick <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
      pix_multi <= 1'b0;
    end else begin
      state <= nxt;
      sync_err <= fail;
      pix_valid <= report;
      frame_tick <= vs_lead;
      if (report) begin
        pix_x <= sx;
        pix_y <= sy;
        pix_rgb <= srgb;
        pix_multi <= smulti;
      end
    end
  end
endmodule

// File: tb/tb_vga_pixel_tracker.sv
// tb_vga_pixel_tracker: drives a reduced-size raster image and checks lock and pixel reports
module tb_vga_pixel_tracker;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3, VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] vga_in = 8'h88;
  logic locked, sync_err, pix_valid, pix_multi, frame_tick;
  logic [9:0] pix_x, pix_y;
  logic [5:0] pix_rgb;
  logic [5:0] img [VT][HT];
  int checks = 0, errors = 0, nvalid = 0, nticks = 0, nerr = 0;
  int mx = 0, my = 0, mc = 0, mm = 0;
  always #5 clk = ~clk;
  vga_pixel_tracker #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst(rst), .vga_in(vga_in), .locked(locked), .sync_err(sync_err),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .pix_multi(pix_multi), .frame_tick(frame_tick));
  always @(negedge clk) begin
    if (pix_valid) nvalid <= nvalid + 1;
    if (frame_tick) nticks <= nticks + 1;
    if (sync_err) nerr <= nerr + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] enc(input int h, input int v);
    logic [5:0] c;
    logic hs_n, vs_n;
    c = img[v][h];
    hs_n = !(h >= HA + HF && h < HA + HF + HS);
    vs_n = !(v >= VA + VF && v < VA + VF + VS);
    return {hs_n, c[0], c[2], c[4], vs_n, c[1], c[3], c[5]};
  endfunction
  task automatic clear_img();
    for (int v = 0; v < VT; v++) for (int h = 0; h < HT; h++) img[v][h] = '0;
  endtask
  task automatic send(input int short_row, input int stop_row);
    for (int v = 0; v < stop_row; v++)
      for (int h = 0; h < (v == short_row ? HT - 1 : HT); h++) begin
        @(posedge clk);
        #1 vga_in = enc(h, v);
      end
  endtask
  task automatic frame(input string tag, input int short_row, input bit exp_lock,
                       input bit exp_rep, input bit exp_err);
    int v0, t0, e0, n, ex, ey, ec;
    n = 0; ex = 0; ey = 0; ec = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (img[y][x] != 0) begin
          if (n == 0) begin ex = x; ey = y; ec = int'(img[y][x]); end
          n++;
        end
    v0 = nvalid; t0 = nticks; e0 = nerr;
    send(short_row, VT);
    if (exp_rep && n > 0) begin mx = ex; my = ey; mc = ec; mm = n > 1 ? 1 : 0; end
    chk({tag, " tick"}, nticks - t0, 1);
    chk({tag, " locked"}, {31'd0, locked}, {31'd0, exp_lock});
    chk({tag, " sync_err"}, nerr - e0, {31'd0, exp_err});
    chk({tag, " valid"}, nvalid - v0, (exp_rep && n > 0) ? 1 : 0);
    chk({tag, " x"}, {22'd0, pix_x}, mx);
    chk({tag, " y"}, {22'd0, pix_y}, my);
    chk({tag, " rgb"}, {26'd0, pix_rgb}, mc);
    chk({tag, " multi"}, {31'd0, pix_multi}, mm);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " locked"}, {31'd0, locked}, 0);
    chk({tag, " sync_err"}, {31'd0, sync_err}, 0);
    chk({tag, " valid"}, {31'd0, pix_valid}, 0);
    chk({tag, " tick"}, {31'd0, frame_tick}, 0);
    chk({tag, " xy"}, {12'd0, pix_x, pix_y}, 0);
    chk({tag, " rgb"}, {26'd0, pix_rgb}, 0);
    chk({tag, " multi"}, {31'd0, pix_multi}, 0);
  endtask
  initial begin
    clear_img();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    frame("t1a", -1, 0, 0, 0);
    frame("t1b", -1, 1, 0, 0);
    frame("t1c", -1, 1, 1, 0);
    img[0][0] = 6'b110000;
    frame("t2", -1, 1, 1, 0);
    clear_img();
    img[VA-1][HA-1] = 6'b000011;
    img[5][10] = 6'b001100;
    frame("t3", -1, 1, 1, 0);
    for (int f = 0; f < 5; f++) begin
      int n;
      clear_img();
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++)
        img[$urandom_range(0, VA - 1)][$urandom_range(0, HA - 1)] = 6'($urandom_range(1, 63));
      frame("rand", -1, 1, 1, 0);
    end
    clear_img();
    img[2][HA + HF + 2] = 6'b111111;
    img[VA + 1][3] = 6'b010101;
    img[3][HA] = 6'b100000;
    frame("t5", -1, 1, 1, 0);
    clear_img();
    img[1][3] = 6'b000001;
    frame("t4bad", 3, 0, 0, 1);
    img[4][6] = 6'b000010;
    frame("t4chk", -1, 1, 0, 0);
    clear_img();
    img[6][12] = 6'b101010;
    frame("t4rep", -1, 1, 1, 0);
    send(-1, 5);
    #1 rst = 1'b1;
    #1 chk_zero("t6 rst");
    mx = 0; my = 0; mc = 0; mm = 0;
    repeat (3) @(posedge clk);
    #1 vga_in = 8'h88;
    rst = 1'b0;
    img[2][7] = 6'b011000;
    frame("t6a", -1, 0, 0, 0);
    frame("t6b", -1, 1, 0, 0);
    frame("t6c", -1, 1, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
